snake_ctrl: RTL and testbench

SNAKE_CTRL -- requirements
Module: snake_ctrl

---
 rtl/snake_ctrl.sv | 118 +++++++++++
 tb/tb_snake_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_ctrl.sv
// Snake game controller: step timer, direction register with reversal guard,
// head position with toroidal wrap, run/over state and saturating score.
module snake_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] go,
  input  logic       collide,
  input  logic       food_eaten,
  output logic       move_tick,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [3:0] dir,
  output logic [1:0] state,
  output logic [7:0] score
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] OVER = 2'b10;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [5:0]  X_MAX   = 6'(GRID_W - 1);
  localparam logic [5:0]  X_HOME  = 6'(GRID_W / 2);
  localparam logic [4:0]  Y_MAX   = 5'(GRID_H - 1);
  localparam logic [4:0]  Y_HOME  = 5'(GRID_H / 2);
  localparam logic [31:0] CNT_MAX = 32'(TICK_DIV - 1);

  logic [3:0]  pending;
  logic [3:0]  req_dir;
  logic [3:0]  opposite;
  logic [31:0] counter;
  logic [5:0]  next_x;
  logic [4:0]  next_y;
  logic        req_center;
  logic        req_valid;
  logic        req_ok;
  logic        wrap;

  // Request decode; the reversal guard compares against the committed direction
  always_comb begin
    req_center = go[4];
    req_dir    = 4'b0000;
    if (go[0])      req_dir = DIR_UP;
    else if (go[1]) req_dir = DIR_DOWN;
    else if (go[2]) req_dir = DIR_LEFT;
    else if (go[3]) req_dir = DIR_RIGHT;
    req_valid = |req_dir;
    opposite  = {dir[2], dir[3], dir[0], dir[1]};
    req_ok    = req_valid && (req_dir != opposite);
    wrap      = (counter == CNT_MAX);
  end

  always_comb begin
    next_x = head_x;
    next_y = head_y;
    case (pending)
      DIR_UP:    next_y = (head_y == 5'd0)  ? Y_MAX : head_y - 5'd1;
      DIR_DOWN:  next_y = (head_y == Y_MAX) ? 5'd0  : head_y + 5'd1;
      DIR_LEFT:  next_x = (head_x == 6'd0)  ? X_MAX : head_x - 6'd1;
      DIR_RIGHT: next_x = (head_x == X_MAX) ? 6'd0  : head_x + 6'd1;
      default:   ;
    endcase
  end

  // Center acts as a soft reset from any state
  always_ff @(posedge clk) begin
    if (reset || req_center) begin
      state     <= IDLE;
      head_x    <= X_HOME;
      head_y    <= Y_HOME;
      dir       <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      score     <= 8'd0;
      counter   <= 32'd0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state   <= RUN;
            dir     <= req_dir;
            pending <= req_dir;
            counter <= 32'd0;
          end
        end
        RUN: begin
          if (collide) begin
            state <= OVER;
          end else begin
            if (food_eaten && (score != 8'hFF)) score <= score + 8'd1;
            if (wrap) begin
              counter   <= 32'd0;
              head_x    <= next_x;
              head_y    <= next_y;
              dir       <= pending;
              move_tick <= 1'b1;
            end else begin
              counter <= counter + 32'd1;
            end
            if (req_ok) pending <= req_dir;
          end
        end
        OVER:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Self-checking bench for snake_ctrl: per-cycle scoreboard against a bench
// model, table-driven segments with hand-derived checkpoints, and corner sequences.
module tb_snake_ctrl;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] go = 5'd0;
  logic       collide = 1'b0;
  logic       food_eaten = 1'b0;
  logic       move_tick;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [3:0] dir;
  logic [1:0] state;
  logic [7:0] score;

  snake_ctrl #(.GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .collide    (collide),
    .food_eaten (food_eaten),
    .move_tick  (move_tick),
    .head_x     (head_x),
    .head_y     (head_y),
    .dir        (dir),
    .state      (state),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    int         x;
    int         y;
    logic [3:0] d;
    int         sc;
    logic       mt;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [4:0] go;
    logic       col;
    logic       food;
    int         n;
    logic [1:0] st;
    int         x;
    int         y;
    logic [3:0] d;
    int         sc;
  } vec_t;

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures = 0;

  logic [1:0] m_st;
  int         m_x, m_y, m_sc, m_cnt;
  logic [3:0] m_d, m_p;
  logic       m_mt;

  function automatic logic [3:0] decodeDir(input logic [4:0] g);
    if (g[0]) return 4'b0001;
    if (g[1]) return 4'b0010;
    if (g[2]) return 4'b0100;
    if (g[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] oppositeOf(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      default: return 4'b0100;
    endcase
  endfunction

  task automatic modelStep(input logic r, input logic [4:0] g, input logic c, input logic f);
    logic [3:0] rq;
    logic [3:0] np;
    rq = decodeDir(g);
    m_mt = 1'b0;
    if (r || g[4]) begin
      m_st = 2'b00; m_x = GW / 2; m_y = GH / 2; m_d = 4'b1000; m_p = 4'b1000;
      m_sc = 0; m_cnt = 0;
    end else if (m_st == 2'b00) begin
      if (rq != 4'b0000) begin
        m_st = 2'b01; m_d = rq; m_p = rq; m_cnt = 0;
      end
    end else if (m_st == 2'b01) begin
      if (c) begin
        m_st = 2'b10;
      end else begin
        if (f && m_sc < 255) m_sc = m_sc + 1;
        np = m_p;
        if (rq != 4'b0000 && rq != oppositeOf(m_d)) np = rq;
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
          case (m_p)
            4'b0001: m_y = (m_y + GH - 1) % GH;
            4'b0010: m_y = (m_y + 1) % GH;
            4'b0100: m_x = (m_x + GW - 1) % GW;
            default: m_x = (m_x + 1) % GW;
          endcase
          m_d = m_p;
          m_mt = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_p = np;
      end
    end
  endtask

  task automatic checkVal(input string name, input int act, input int expv);
    assertions++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    checkVal("state", int'(state), int'(e.st));
    checkVal("head_x", int'(head_x), e.x);
    checkVal("head_y", int'(head_y), e.y);
    checkVal("dir", int'(dir), int'(e.d));
    checkVal("score", int'(score), e.sc);
    checkVal("move_tick", int'(move_tick), int'(e.mt));
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] g, input logic c, input logic f);
    exp_t e;
    reset = r; go = g; collide = c; food_eaten = f;
    modelStep(r, g, c, f);
    e.st = m_st; e.x = m_x; e.y = m_y; e.d = m_d; e.sc = m_sc; e.mt = m_mt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  vec_t vecs[15];

  initial begin
    // rst, go, col, food, cycles, state, x, y, dir, score after the segment
    vecs[0]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 2, 2'b00, 20, 15, 4'b1000, 0};
    vecs[1]  = '{1'b0, 5'b01000, 1'b0, 1'b0, 1, 2'b01, 20, 15, 4'b1000, 0};
    vecs[2]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 8, 2'b01, 22, 15, 4'b1000, 0};
    vecs[3]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 1, 2'b01, 22, 15, 4'b1000, 0};
    vecs[4]  = '{1'b0, 5'b00001, 1'b0, 1'b0, 1, 2'b01, 22, 15, 4'b1000, 0};
    vecs[5]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 2, 2'b01, 22, 14, 4'b0001, 0};
    vecs[6]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 1, 2'b01, 22, 14, 4'b0001, 1};
    vecs[7]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 3, 2'b01, 22, 13, 4'b0001, 1};
    vecs[8]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 3, 2'b01, 22, 13, 4'b0001, 1};
    vecs[9]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 1, 2'b10, 22, 13, 4'b0001, 1};
    vecs[10] = '{1'b0, 5'b00000, 1'b0, 1'b1, 5, 2'b10, 22, 13, 4'b0001, 1};
    vecs[11] = '{1'b0, 5'b01000, 1'b0, 1'b0, 2, 2'b10, 22, 13, 4'b0001, 1};
    vecs[12] = '{1'b0, 5'b10000, 1'b1, 1'b1, 1, 2'b00, 20, 15, 4'b1000, 0};
    vecs[13] = '{1'b0, 5'b01110, 1'b0, 1'b0, 1, 2'b01, 20, 15, 4'b0010, 0};
    vecs[14] = '{1'b0, 5'b10011, 1'b0, 1'b0, 1, 2'b00, 20, 15, 4'b1000, 0};

    #1;
    for (int v = 0; v < 15; v++) begin
      for (int k = 0; k < vecs[v].n; k++)
        applyStimulus(vecs[v].rst, vecs[v].go, vecs[v].col, vecs[v].food);
      checkVal($sformatf("vec%0d state", v), int'(state), int'(vecs[v].st));
      checkVal($sformatf("vec%0d head_x", v), int'(head_x), vecs[v].x);
      checkVal($sformatf("vec%0d head_y", v), int'(head_y), vecs[v].y);
      checkVal($sformatf("vec%0d dir", v), int'(dir), int'(vecs[v].d));
      checkVal($sformatf("vec%0d score", v), int'(score), vecs[v].sc);
    end

    // Right edge wrap
    applyStimulus(1'b0, 5'b01000, 1'b0, 1'b0);
    idle(76);
    checkVal("x reaches 39", int'(head_x), 39);
    idle(4);
    checkVal("x wraps right to 0", int'(head_x), 0);

    // Left edge wrap
    applyStimulus(1'b0, 5'b10000, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00100, 1'b0, 1'b0);
    idle(80);
    checkVal("x reaches 0", int'(head_x), 0);
    idle(4);
    checkVal("x wraps left to 39", int'(head_x), 39);

    // Top edge wrap
    applyStimulus(1'b0, 5'b10000, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00001, 1'b0, 1'b0);
    idle(60);
    checkVal("y reaches 0", int'(head_y), 0);
    idle(4);
    checkVal("y wraps up to 29", int'(head_y), 29);

    // Score saturation
    applyStimulus(1'b0, 5'b10000, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b01000, 1'b0, 1'b0);
    for (int k = 0; k < 260; k++) applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkVal("score saturates", int'(score), 255);
    checkVal("still running", int'(state), 1);

    // Reset mid-step at counter 2, with competing inputs
    applyStimulus(1'b0, 5'b10000, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00010, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 5'b00100, 1'b1, 1'b1);
    checkVal("mid-run reset state", int'(state), 0);
    checkVal("mid-run reset head_x", int'(head_x), 20);
    checkVal("mid-run reset head_y", int'(head_y), 15);
    checkVal("mid-run reset dir", int'(dir), 8);
    checkVal("mid-run reset move_tick", int'(move_tick), 0);

    // Reset out of OVER
    applyStimulus(1'b0, 5'b01000, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b1, 1'b0);
    checkVal("collide enters over", int'(state), 2);
    applyStimulus(1'b1, 5'b00000, 1'b0, 1'b0);
    checkVal("reset leaves over", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
